csa_resolve: RTL and testbench
==============================

CSA_RESOLVE -- requirements
Module: csa_resolve

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port S, input, 32 bits: redundant-form sum word from the 3:2 compressor stage.
REQ-004 SHALL have port Ca, input, 32 bits: redundant-form carry word, already left-aligned (Ca[0] normally 0).
REQ-005 SHALL have port in_valid, input, 1 bit: S/Ca pair is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a pair.
REQ-007 SHALL have port P, output, 32 bits: resolved binary result, (S + Ca) mod 2^32.
REQ-008 SHALL have port out_valid, output, 1 bit: P is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts P.
REQ-010 SHALL have port ovf, output, 1 bit: carry out of bit 31; present only when CSA_RESOLVE_OVF_EN is defined.

Function
REQ-011 SHALL implement an iterative carry-propagate adder resolving 8 bits per cycle, LSB chunk first, with a 1-bit carry register between chunks.
REQ-012 SHALL use states IDLE, RUN and DONE; state is IDLE out of reset.
REQ-013 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 IDLE: on in_valid & in_ready, SHALL capture S and Ca, clear the carry register, clear chunk counter cnt[1:0] to 0, and go to RUN.
REQ-015 RUN: each cycle, SHALL compute P[8k+7:8k] = S chunk + Ca chunk + carry for k = cnt, update carry, and increment cnt.
REQ-016 RUN with cnt = 3: SHALL write the final chunk and go to DONE.
REQ-017 Latency SHALL be exactly 4 cycles: out_valid rises on the 4th rising edge after the accepting edge.
REQ-018 DONE: SHALL hold P (and ovf) stable until out_ready = 1; on out_valid & out_ready, SHALL go to IDLE, so in_ready = 1 the following cycle.
REQ-019 SHALL never overlap operations; a new pair can be accepted no sooner than the cycle after the handshake completes, so throughput is one result per 6 cycles minimum.
REQ-020 SHALL ignore in_valid and input changes while in RUN or DONE, because the operands are registered.
REQ-021 SHALL use the full value of Ca[0]; a nonzero Ca[0] is added normally and is not masked.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, P = 0, out_valid = 0, in_ready = 1 once released, carry = 0, cnt = 0, ovf = 0.
REQ-023 Reset asserted in RUN or DONE SHALL discard the operation in progress; no out_valid follows.
REQ-024 After rst_n deassertion, the first rising edge SHALL be able to accept a pair.

Configuration
REQ-025 With CSA_RESOLVE_OVF_EN defined, the ovf port SHALL exist and carry the final carry register value, updated with the last chunk and held with P in DONE.
REQ-026 Without CSA_RESOLVE_OVF_EN, the ovf port and its logic SHALL be absent, and the carry out of bit 31 SHALL be discarded.

Verification
REQ-027 S=0x0000_0005, Ca=0x0000_000A, out_ready=1 -> P=0x0000_000F, out_valid exactly 4 edges after accept, in_ready high 1 cycle later.
REQ-028 S=0x00FF_FFFF, Ca=0x0000_0002 -> P=0x0100_0001; carry propagates across 3 chunk boundaries.
REQ-029 S=0xFFFF_FFFF, Ca=0x0000_0002 -> P=0x0000_0001; ovf=1 with the macro defined, port absent without it.
REQ-030 out_ready held low 10 cycles after out_valid -> P stable, in_ready=0, and a second in_valid pulse is ignored; the result is released on the out_ready pulse.
REQ-031 rst_n pulsed low during RUN (cnt=2) -> P=0 and out_valid=0 immediately; next pair S=1, Ca=1 -> P=2.
REQ-032 Back-to-back pairs with in_valid held high -> each result is correct, and pairs are accepted only in IDLE cycles.

Source files
------------

// File: rtl/csa_resolve.sv
// Iterative carry-propagate resolver for a redundant (sum, carry) pair: 8 bits per cycle.
// Optional carry-out port enabled with `define CSA_RESOLVE_OVF_EN.
module csa_resolve (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] S,
  input  logic [31:0] Ca,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] P,
  output logic        out_valid,
  input  logic        out_ready
`ifdef CSA_RESOLVE_OVF_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] s_q;
  logic [31:0] ca_q;
  logic [31:0] p_q;
  logic        carry_q;
  logic [1:0]  cnt_q;

  logic        accept;
  logic        step;
  logic        last;
  logic        release_res;

  logic [4:0]  base;
  logic [8:0]  chunk_sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid)            state_d = StRun;
      StRun:  if (cnt_q == 2'd3)       state_d = StDone;
      StDone: if (out_ready)           state_d = StIdle;
      default:                         state_d = StIdle;
    endcase
  end

  // Outputs and datapath controls
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    step        = 1'b0;
    last        = 1'b0;
    release_res = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      StRun: begin
        step = 1'b1;
        last = (cnt_q == 2'd3);
      end
      StDone: begin
        out_valid   = 1'b1;
        release_res = out_ready;
      end
      default: ;
    endcase
  end

  assign base      = {cnt_q, 3'b000};
  assign chunk_sum = {1'b0, s_q[base +: 8]} + {1'b0, ca_q[base +: 8]} + {8'd0, carry_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      ca_q    <= '0;
      p_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= 2'd0;
    end else if (accept) begin
      s_q     <= S;
      ca_q    <= Ca;
      p_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= 2'd0;
    end else if (step) begin
      p_q[base +: 8] <= chunk_sum[7:0];
      carry_q        <= chunk_sum[8];
      cnt_q          <= cnt_q + 2'd1;
    end
  end

  assign P = p_q;

`ifdef CSA_RESOLVE_OVF_EN
  // Separate register so ovf only changes with the final chunk, not mid-run.
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= chunk_sum[8];
    end
  end
  assign ovf = ovf_q;
`endif

  logic unused_release;
  assign unused_release = release_res;

endmodule

// File: tb/tb_csa_resolve.sv
// Directed bench for csa_resolve with a queue scoreboard of expected results.
module tb_csa_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] S, Ca, P;
  logic        in_valid, in_ready, out_valid, out_ready;
`ifdef CSA_RESOLVE_OVF_EN
  logic        ovf;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] p;
    logic        c;
  } exp_t;
  exp_t sb[$];

  csa_resolve dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .S         (S),
    .Ca        (Ca),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (P),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CSA_RESOLVE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] s, input logic [31:0] c);
    logic [32:0] sum;
    exp_t e;
    sum = {1'b0, s} + {1'b0, c};
    e.p = sum[31:0];
    e.c = sum[32];
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_P"}, {32'd0, P}, {32'd0, e.p});
`ifdef CSA_RESOLVE_OVF_EN
      check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, e.c});
`endif
    end
  endtask

  // Drive one pair from IDLE, verify 4-edge latency, optionally stall out_ready.
  task automatic run_op(input string tag, input logic [31:0] s, input logic [31:0] c,
                        input int hold);
    int lat;
    logic [31:0] held;
    check({tag, "_in_ready_idle"}, {63'd0, in_ready}, 64'd1);
    S = s; Ca = c; in_valid = 1'b1;
    sb.push_back(model(s, c));
    step();
    in_valid = 1'b0;
    S = ~s; Ca = ~c;
    check({tag, "_in_ready_run"}, {63'd0, in_ready}, 64'd0);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (out_valid) break;
      step();
      lat = k;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    held = P;
    for (int k = 0; k < hold; k++) begin
      if (k == 2) begin
        in_valid = 1'b1; S = 32'h1234_5678; Ca = 32'h1111_1111;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (k == hold - 1) begin
        check({tag, "_hold_P"}, {32'd0, P}, {32'd0, held});
        check({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      end
    end
    in_valid = 1'b0;
    pop_check(tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_ready_after"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_valid_after"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int accepts;
    int last_acc;
    int results;
    rst_n = 1'b0; S = '0; Ca = '0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    check("reset_P", {32'd0, P}, 64'd0);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    #4;

    run_op("basic", 32'h0000_0005, 32'h0000_000A, 0);
    run_op("carry3", 32'h00FF_FFFF, 32'h0000_0002, 0);
    run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op("ca0", 32'h0000_0010, 32'h0000_0003, 0);
    run_op("mixed", 32'h89AB_CDEF, 32'h7654_3211, 0);
    run_op("stall", 32'hDEAD_BEEF, 32'h0F0F_0F0E, 10);

    // Reset in the middle of RUN (cnt = 2)
    S = 32'hAAAA_AAAA; Ca = 32'h5555_5554; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_P", {32'd0, P}, 64'd0);
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid) check("rst_no_valid", 64'd1, 64'd0);
    end
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    run_op("after_rst", 32'h0000_0001, 32'h0000_0001, 0);

    // Back-to-back with in_valid held high and operands changing every cycle
    out_ready = 1'b1;
    in_valid = 1'b1;
    accepts = 0; results = 0; last_acc = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (out_valid) begin
        pop_check("b2b");
        results++;
      end
      S = $urandom; Ca = $urandom;
      if (in_ready) begin
        if (last_acc >= 0) check("b2b_spacing", 64'(cyc - last_acc), 64'd6);
        sb.push_back(model(S, Ca));
        last_acc = cyc;
        accepts++;
      end
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      if (out_valid) begin
        pop_check("b2b_tail");
        results++;
      end
      step();
    end
    check("b2b_count", 64'(results), 64'(accepts));
    check("b2b_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
